// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog interrupt/reset controller.
// Optional reset generation is compiled in with the WDT_RESET_EN macro.
package wdt_pkg;

    // Controller states: idle, interrupt pending, reset pulse in progress.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PEND  = 2'b01,
        RESET = 2'b10
    } wdt_int_state_e;

    // Default width of the watchdog reset pulse in pclk cycles.
    localparam int unsigned WDT_RST_PULSE_DEF = 16;

    // A state carries an outstanding interrupt whenever it is not idle.
    function automatic logic wdt_int_active(input wdt_int_state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/wdt_rst_stretch.sv
// Loadable down-counter that stretches the watchdog reset request.
// busy is high from the cycle after load until the count has reached zero;
// done marks the final busy cycle (count zero).
module wdt_rst_stretch #(
    parameter int CNT_W = 5
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             load,
    input  logic [CNT_W-1:0] cnt_init,
    output logic             busy,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // Load starts a run; otherwise count down while busy and stop after zero.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (load) begin
            r_cnt  <= cnt_init;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_busy & (r_cnt == '0);

endmodule

// File: rtl/wdt_int_ctrl.sv
// Watchdog interrupt and reset controller, downstream of the WDT timer.
// First expiry raises the interrupt; a second uncleared expiry (with res_en)
// issues a stretched reset request. Reset generation requires WDT_RESET_EN;
// without it the controller is interrupt-only and wdt_rst is tied low.
module wdt_int_ctrl
    import wdt_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = WDT_RST_PULSE_DEF,
    parameter int RST_CNT_W        = $clog2(RST_PULSE_CYCLES + 1)
) (
    input  logic pclk,
    input  logic presetn,
    input  logic value_eq0,
    input  logic int_en,
    input  logic res_en,
    input  logic wr_en_icr,
    output logic ris,
    output logic mis,
    output logic wdt_int,
    output logic wdt_rst
);

    wdt_int_state_e r_state;
    wdt_int_state_e w_state_next;
    logic           w_expire;
    logic           r_ris;

    // The timer only counts while int_en is high, so zero counts as an
    // expiry only in that case. A zero load gives an expiry every cycle.
    assign w_expire = value_eq0 & int_en;

`ifdef WDT_RESET_EN
    logic                 w_load;
    logic                 w_done;
    logic                 w_busy;
    logic                 r_rst;
    logic [RST_CNT_W-1:0] w_cnt_init;

    // The counter runs from N-1 down to 0, giving exactly N pulse cycles.
    assign w_cnt_init = RST_CNT_W'(RST_PULSE_CYCLES - 1);

    wdt_rst_stretch #(
        .CNT_W (RST_CNT_W)
    ) u_rst_stretch (
        .pclk     (pclk),
        .presetn  (presetn),
        .load     (w_load),
        .cnt_init (w_cnt_init),
        .busy     (w_busy),
        .done     (w_done)
    );
`else
    // Interrupt-only build: res_en and the counter width are not needed.
    logic                 w_unused_res_en;
    logic [RST_CNT_W-1:0] w_unused_cnt;
    assign w_unused_res_en = res_en;
    assign w_unused_cnt    = '0;
`endif

    // Next-state decode. Clear beats expiry in PEND; in IDLE a simultaneous
    // clear has nothing to clear, so the expiry sets the interrupt.
    always_comb begin
        w_state_next = r_state;
`ifdef WDT_RESET_EN
        w_load       = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_expire) begin
                    w_state_next = PEND;
                end
            end
            PEND: begin
                if (wr_en_icr) begin
                    w_state_next = IDLE;
                end
`ifdef WDT_RESET_EN
                else if (w_expire && res_en) begin
                    w_state_next = RESET;
                    w_load       = 1'b1;
                end
`endif
            end
`ifdef WDT_RESET_EN
            // Expiries and clears are ignored until the pulse completes.
            RESET: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
`endif
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Raw status is registered from the next state so it cannot glitch on
    // multi-bit state changes.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ris <= 1'b0;
        end else begin
            r_ris <= wdt_int_active(w_state_next);
        end
    end

`ifdef WDT_RESET_EN
    // Reset request is its own flop so downstream reset logic sees a clean
    // edge rather than a decode of the state bits.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rst <= 1'b0;
        end else begin
            r_rst <= (w_state_next == RESET);
        end
    end

    assign wdt_rst = r_rst;
`else
    assign wdt_rst = 1'b0;
`endif

    assign ris     = r_ris;
    assign mis     = r_ris & int_en;
    assign wdt_int = mis;

endmodule

// File: doc/wdt_int_ctrl.md
# wdt_int_ctrl

Watchdog interrupt and reset controller that sits directly downstream of the WDT `timer`. It consumes the timer's zero-reached indication and raises a raw/masked interrupt on the first expiry. On a second expiry with the interrupt still uncleared, it issues a stretched watchdog reset request. Interrupt clear comes from the APB ICR write strobe, the same strobe that reloads the timer.

## Interface
- `RST_PULSE_CYCLES`, default 16: width of the `wdt_rst` pulse in pclk cycles; legal range ≥1.
- `RST_CNT_W`, default `$clog2(RST_PULSE_CYCLES+1)`: width of the pulse counter.
- `pclk`  in  1  clock.
- `presetn`  in  1  reset, asynchronous, active-low.
- `value_eq0`  in  1  timer count is zero (from timer).
- `int_en`  in  1  control INTEN bit; timer counts only while high.
- `res_en`  in  1  control RESEN bit; enables reset generation.
- `wr_en_icr`  in  1  one-cycle APB write strobe to the interrupt-clear register.
- `ris`  out  1  raw interrupt status.
- `mis`  out  1  masked interrupt status, `ris & int_en`.
- `wdt_int`  out  1  interrupt line to the interrupt controller, equal to `mis`.
- `wdt_rst`  out  1  active-high watchdog reset request.

## Operation
- Expiry event: `expire = value_eq0 & int_en`, sampled on each pclk edge. If the timer load is 0, `expire` is high every cycle; this is legal and is handled as consecutive expiries.
- FSM states: IDLE, PEND, RESET. Encoded 2-bit; IDLE is the reset state.
- IDLE:
  - `expire` → PEND.
  - `wr_en_icr` alone has no effect.
  - If `expire` and `wr_en_icr` arrive together → PEND (set wins; there is no prior interrupt to clear).
- PEND:
  - `wr_en_icr` → IDLE. This takes priority over `expire` in the same cycle; the timer reloads on the same strobe.
  - `expire & res_en` → RESET, and the pulse counter loads `RST_PULSE_CYCLES-1`.
  - `expire & ~res_en` → stay in PEND; `ris` stays 1.
  - `int_en` low → stay in PEND; `ris` is held and `mis` drops to 0.
- RESET:
  - `wdt_rst` = 1.
  - The counter decrements each cycle; at count 0 → IDLE.
  - `ris` is cleared on exit.
  - `expire` and `wr_en_icr` are ignored.
- `ris` = 1 in PEND and in RESET, 0 in IDLE.
- All outputs are registered-state driven. There are no combinational paths from inputs to `ris` or `wdt_rst`; `mis` depends on `int_en` combinationally.

## Timing
- Reset values: state IDLE, counter 0, `ris`=0, `mis`=0, `wdt_int`=0, `wdt_rst`=0.
- `expire` sampled at edge n → `ris`=1 after edge n (visible in cycle n+1).
- `wr_en_icr` at edge k in PEND → `ris`=0 in cycle k+1.
- Second `expire` at edge m (PEND, `res_en`=1) → `wdt_rst`=1 for exactly `RST_PULSE_CYCLES` cycles, m+1 through m+`RST_PULSE_CYCLES`. IDLE is reached in cycle m+`RST_PULSE_CYCLES`+1.
- `presetn` asserted mid-pulse → `wdt_rst` and `ris` go to 0 asynchronously and the FSM goes to IDLE.
- `res_en` is sampled only at the transition edge; changing it during RESET does not shorten the pulse.

## Configuration
- Macro: `WDT_RESET_EN`.
- Defined: behaviour as above.
- Undefined:
  - The RESET state and the pulse counter are not compiled in.
  - `wdt_rst` is tied 0.
  - `res_en` is unused.
  - In PEND, a second `expire` keeps PEND; only `wr_en_icr` leaves PEND.

## Structure
- `wdt_pkg` holds:
  - the state typedef `wdt_int_state_e` (IDLE, PEND, RESET);
  - the constant `WDT_RST_PULSE_DEF` = 16, used as the parameter default.
- One sub-module, `wdt_rst_stretch`: a loadable down-counter that takes `load`/`cnt_init` and produces `busy` and `done`. It is instantiated only under `WDT_RESET_EN`.

## Test plan
- Reset: hold `presetn`=0 with all inputs toggling → `ris`, `mis`, `wdt_int`, `wdt_rst` all 0. Release → still 0.
- Single expiry and clear: `int_en`=1, one `value_eq0` pulse → `ris`=`mis`=`wdt_int`=1 next cycle. `wr_en_icr` 5 cycles later → all 0 the following cycle.
- Reset generation: `RST_PULSE_CYCLES`=16, `res_en`=1, two expiries 10 cycles apart → `wdt_rst` high for exactly 16 cycles starting the cycle after the second expiry, then `ris`=0.
- Reset disabled: `res_en`=0, three expiries → `wdt_rst` stays 0 and `ris` stays 1. Then `int_en`=0 → `mis`=0, `ris`=1.
- Simultaneous events:
  - In PEND, `value_eq0` and `wr_en_icr` on the same edge → IDLE, `wdt_rst`=0.
  - In IDLE, the same pair → PEND.
- Async reset mid-pulse: assert `presetn`=0 in pulse cycle 7 → `wdt_rst`=0 immediately. After release, one expiry → PEND only.
